// File: rtl/uarts_tx.sv
// uarts_tx: UART transmitter for the uarts peripheral.
// Sends a 32-bit word as 1, 2 or 4 frames, least-significant byte first.
// Each frame is a start bit, 8 data bits LSB first, an optional parity bit
// and one stop bit. The frames of one word follow each other with no idle gap.
// A one-cycle tx_irq pulse marks the end of the word.
module uarts_tx (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] uarts_baud,
   input  logic [31:0] uarts_ctl,
   input  logic        tx_start,
   input  logic [31:0] tx_data,
   output logic        TX,
   output logic        tx_busy,
   output logic        tx_irq
);

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   tx_state_e   state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;   // cycles left in the current bit
   logic [15:0] baud_q, baud_d;           // bit period minus 1, held for the word
   logic [2:0]  bit_cnt_q, bit_cnt_d;     // data bit index within the frame
   logic [1:0]  bytes_q, bytes_d;         // frames still to send after this one
   logic [7:0]  shift_q, shift_d;         // byte being serialised, bit 0 on the line
   logic [23:0] word_q, word_d;           // upper bytes still waiting to be sent
   logic        par_q, par_d;             // parity bit of the current byte
   logic        par_en_q, par_en_d;
   logic        par_even_q, par_even_d;
   logic        tx_q, tx_d;
   logic        irq_q, irq_d;
   logic        tick;

   // Configuration bits the transmitter does not use.
   logic        unused_cfg;
   assign unused_cfg = ^{uarts_baud[31:16], uarts_ctl[31:4]};

   // Parity over one byte: even parity is the XOR of the bits, odd is its inverse.
   function automatic logic parity_bit(input logic [7:0] data, input logic even);
      parity_bit = even ? (^data) : ~(^data);
   endfunction

   // Frames remaining after the first one, from the word size field.
   function automatic logic [1:0] extra_bytes(input logic [1:0] size);
      case (size)
         2'b01:   extra_bytes = 2'd1;
         2'b10:   extra_bytes = 2'd3;
         default: extra_bytes = 2'd0;
      endcase
   endfunction

   assign tick    = (baud_cnt_q == 16'd0);
   assign TX      = tx_q;
   assign tx_busy = (state_q != TX_IDLE);
   assign tx_irq  = irq_q;

   // Next-state logic: bit timing, framing and byte sequencing.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      baud_d     = baud_q;
      bit_cnt_d  = bit_cnt_q;
      bytes_d    = bytes_q;
      shift_d    = shift_q;
      word_d     = word_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      par_even_d = par_even_q;
      irq_d      = 1'b0;

      case (state_q)
         TX_IDLE: begin
            // Idle means not busy, so any request here is accepted.
            if (tx_start) begin
               state_d    = TX_START;
               baud_d     = uarts_baud[15:0];
               baud_cnt_d = uarts_baud[15:0];
               bit_cnt_d  = 3'd0;
               bytes_d    = extra_bytes(uarts_ctl[1:0]);
               shift_d    = tx_data[7:0];
               word_d     = tx_data[31:8];
               par_en_d   = uarts_ctl[2];
               par_even_d = uarts_ctl[3];
               par_d      = parity_bit(tx_data[7:0], uarts_ctl[3]);
            end
         end

         TX_START: begin
            if (tick) begin
               state_d    = TX_DATA;
               baud_cnt_d = baud_q;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         TX_DATA: begin
            if (tick) begin
               baud_cnt_d = baud_q;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  state_d   = par_en_q ? TX_PARITY : TX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         TX_PARITY: begin
            if (tick) begin
               state_d    = TX_STOP;
               baud_cnt_d = baud_q;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         TX_STOP: begin
            if (tick) begin
               baud_cnt_d = baud_q;
               if (bytes_q != 2'd0) begin
                  // Next byte starts straight after this stop bit.
                  state_d = TX_START;
                  bytes_d = bytes_q - 2'd1;
                  shift_d = word_q[7:0];
                  word_d  = word_q >> 8;
                  par_d   = parity_bit(word_q[7:0], par_even_q);
               end else begin
                  state_d = TX_IDLE;
                  irq_d   = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   // Line level for the coming cycle, taken from the next state so TX is glitch-free.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_d[0];
         TX_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset abandons any word in flight.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= TX_IDLE;
         baud_cnt_q <= 16'd0;
         baud_q     <= 16'd0;
         bit_cnt_q  <= 3'd0;
         bytes_q    <= 2'd0;
         shift_q    <= 8'd0;
         word_q     <= 24'd0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         par_even_q <= 1'b0;
         tx_q       <= 1'b1;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         baud_q     <= baud_d;
         bit_cnt_q  <= bit_cnt_d;
         bytes_q    <= bytes_d;
         shift_q    <= shift_d;
         word_q     <= word_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         par_even_q <= par_even_d;
         tx_q       <= tx_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: doc/uarts_tx.md
Name: uarts_tx

Overview:
- UART transmitter, the partner of the UART receiver in the uarts peripheral.
- Serialises a 32-bit word as 1, 2 or 4 byte frames, least-significant byte first, on the TX pin.
- Each frame is: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Has its own baud-rate counter. Reports completion to the register block with a one-cycle interrupt.

Parameters:
- None. All configuration comes from uarts_baud and uarts_ctl.

Ports:
- hclk  input  1  clock
- hresetn  input  1  asynchronous, active-low reset
- uarts_baud  input  32  [15:0] = clocks per bit minus 1; [31:16] ignored
- uarts_ctl  input  32  [1:0] word size: 00 = 8b, 01 = 16b, 10 = 32b, 11 = 8b; [2] parity enable; [3] 1 = even parity, 0 = odd parity
- tx_start  input  1  single-cycle request to send tx_data
- tx_data  input  32  word to send, sampled when tx_start is accepted
- TX  output  1  serial line, idles high
- tx_busy  output  1  high while a word is in flight
- tx_irq  output  1  one-cycle pulse when the word is complete

Behaviour:
- Reset values: TX = 1, tx_busy = 0, tx_irq = 0, FSM = TX_IDLE, all counters = 0, shift register = 0.
- Reset is asynchronous and may arrive mid-frame. It forces TX = 1 at once and abandons the word. No tx_irq is produced for that word.
- Accept rule: a request is accepted on a rising edge where tx_start = 1 and tx_busy = 0.
- On accept, latch tx_data, uarts_ctl[3:0] and uarts_baud[15:0]. Later changes to these inputs do not affect the word in flight.
- tx_start while tx_busy = 1 is ignored. It is not queued.
- Byte count per word: 1 for ctl[1:0] = 00 or 11, 2 for 01, 4 for 10.
- Bit period = latched baud[15:0] + 1 clocks. Baud 0 gives 1 clock per bit.
- A baud counter reloads at the start of every bit and counts down to 0. When it reaches 0, the FSM advances.
- FSM states:
  - TX_IDLE: TX = 1. On accept, go to TX_START. tx_busy = 1 from the next cycle.
  - TX_START: TX = 0 for one bit period, then go to TX_DATA.
  - TX_DATA: TX = shift register bit 0. Shift right once per bit period. After 8 bits, go to TX_PARITY if parity is enabled, otherwise TX_STOP.
  - TX_PARITY: TX = parity bit for one bit period, then go to TX_STOP.
  - TX_STOP: TX = 1 for one bit period. If more bytes remain, go to TX_START with the next byte. Otherwise go to TX_IDLE.
- Parity bit = XOR of the 8 data bits when even parity is selected, and its inverse when odd parity is selected.
- Consecutive bytes of one word are sent back to back. The stop bit of one byte is followed directly by the start bit of the next, with no idle gap.
- Latency:
  - TX falls on the first cycle after the accept edge.
  - The word lasts N × F × (baud + 1) cycles, where N is the byte count and F is the frame length: 10 bits, or 11 with parity.
- Completion:
  - The cycle after the last stop bit period, tx_busy = 0 and tx_irq = 1 for exactly one cycle.
  - A new tx_start in that same cycle is accepted. It starts the next word with no extra gap, so TX stays high for one cycle only.

Test Plan:
- Reset → TX = 1, tx_busy = 0, tx_irq = 0.
- baud = 3, ctl = 0, tx_start with data 0x000000A5 → TX = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. tx_busy is high for 40 cycles, then one tx_irq pulse.
- ctl = 0x4 (parity on, odd), data 0xA5 → parity bit = 1 and the frame is 11 bits. ctl = 0xC (even) → parity bit = 0. ctl = 0x4, data 0xA4 → parity bit = 0.
- ctl = 0x1, baud = 0, data 0x00001234 → byte 0x34 then byte 0x12, 20 cycles total, no gap between frames, one tx_irq. ctl = 0x2, data 0xDEADBEEF → bytes EF, BE, AD, DE, 40 cycles. ctl = 0x3 → 8-bit word.
- Pulse tx_start with a different data value mid-word → ignored, the original word completes unchanged. Change uarts_ctl and uarts_baud mid-word → no effect on the word in flight.
- Assert hresetn low mid-DATA → TX = 1 immediately and no tx_irq. After release, a new word transmits correctly. Also check back-to-back: tx_start in the tx_irq cycle is accepted.
